// File: rtl/imem_boot_loader.sv
// imem_boot_loader: after every reset, fills imem with NOP words, then loads a header-framed
//   little-endian word image from a valid/ready byte stream and releases the core from reset.
// Latency: one imem write per fill cycle; each image word is written on the edge that accepts
//   its 4th byte; load_done/core_rst_n rise on the edge after FIN is entered.
// Backpressure: in_ready is low during fill, after the last expected byte, in DONE and in ERROR;
//   the loader never throttles while an image is in flight.
// Optional feature macro CHECKSUM_EN: a trailing byte holding the XOR of all data bytes is
//   expected after the data (or directly after a zero-length header) and verified.
module imem_boot_loader #(
  parameter int          DEPTH    = 64,
  parameter int          AW       = $clog2(DEPTH),
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          core_rst_n,
  output logic          load_done,
  output logic          load_error,
  output logic [AW:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_FILL,
    S_HDR_LO,
    S_HDR_HI,
    S_DATA,
`ifdef CHECKSUM_EN
    S_CSUM,
`endif
    S_FIN,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [AW-1:0] FILL_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] FILL_STEP = AW'(1);
  localparam logic [AW:0]   WORD_STEP = (AW + 1)'(1);

  state_t        r_state;
  logic [AW-1:0] r_fill_cnt;   // next NOP fill address
  logic [7:0]    r_n_lo;       // low byte of the word count, held until the high byte arrives
  logic [AW:0]   r_n;          // validated word count of the image
  logic [23:0]   r_asm;        // first three bytes of the word being assembled, byte 0 lowest
  logic [1:0]    r_byte_idx;   // byte position within the current word
`ifdef CHECKSUM_EN
  logic [7:0]    r_csum;       // running XOR of data bytes
`endif

  logic          w_accept;
  logic [15:0]   w_hdr_n;
  logic          w_hdr_too_big;
  logic          w_hdr_zero;
  logic [31:0]   w_word;
  logic          w_word_done;
  logic          w_last_word;
`ifdef CHECKSUM_EN
  logic          w_csum_ok;
`endif

  // Decode of the byte presented this cycle against the current framing context
  always_comb begin
    w_accept      = in_valid & in_ready;
    w_hdr_n       = {in_data, r_n_lo};
    w_hdr_too_big = (w_hdr_n > 16'(DEPTH));
    w_hdr_zero    = (w_hdr_n == 16'd0);
    w_word        = {in_data, r_asm};
    w_word_done   = (r_byte_idx == 2'd3);
    w_last_word   = ((words_loaded + WORD_STEP) == r_n);
`ifdef CHECKSUM_EN
    w_csum_ok     = (in_data == r_csum);
`endif
  end

  // Loader FSM: fill, header, data, optional checksum, then terminal DONE/ERROR; all outputs registered
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_FILL;
      r_fill_cnt   <= '0;
      r_n_lo       <= '0;
      r_n          <= '0;
      r_asm        <= '0;
      r_byte_idx   <= '0;
`ifdef CHECKSUM_EN
      r_csum       <= '0;
`endif
      in_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      core_rst_n   <= 1'b0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
    end else begin
      // imem_we is a one-cycle strobe unless a state below raises it
      imem_we <= 1'b0;

      case (r_state)
        S_FILL: begin
          imem_we    <= 1'b1;
          imem_addr  <= r_fill_cnt;
          imem_wdata <= NOP_WORD;
          r_fill_cnt <= r_fill_cnt + FILL_STEP;
          if (r_fill_cnt == FILL_LAST) begin
            r_state <= S_HDR_LO;
          end
        end

        S_HDR_LO: begin
          in_ready <= 1'b1;
          if (w_accept) begin
            r_n_lo  <= in_data;
            r_state <= S_HDR_HI;
          end
        end

        S_HDR_HI: begin
          if (w_accept) begin
            if (w_hdr_too_big) begin
              // Oversized image: refuse it before any data word can be written
              in_ready   <= 1'b0;
              load_error <= 1'b1;
              r_state    <= S_ERROR;
            end else if (w_hdr_zero) begin
              r_n <= '0;
`ifdef CHECKSUM_EN
              r_state <= S_CSUM;
`else
              in_ready <= 1'b0;
              r_state  <= S_FIN;
`endif
            end else begin
              r_n     <= w_hdr_n[AW:0];
              r_state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (w_accept) begin
            r_asm      <= w_word[31:8];
            r_byte_idx <= r_byte_idx + 2'd1;
`ifdef CHECKSUM_EN
            r_csum     <= r_csum ^ in_data;
`endif
            if (w_word_done) begin
              imem_we      <= 1'b1;
              imem_addr    <= words_loaded[AW-1:0];
              imem_wdata   <= w_word;
              words_loaded <= words_loaded + WORD_STEP;
              if (w_last_word) begin
`ifdef CHECKSUM_EN
                r_state <= S_CSUM;
`else
                in_ready <= 1'b0;
                r_state  <= S_FIN;
`endif
              end
            end
          end
        end

`ifdef CHECKSUM_EN
        S_CSUM: begin
          if (w_accept) begin
            in_ready <= 1'b0;
            if (w_csum_ok) begin
              r_state <= S_FIN;
            end else begin
              load_error <= 1'b1;
              r_state    <= S_ERROR;
            end
          end
        end
`endif

        S_FIN: begin
          // The last imem write strobe is already retired here, so releasing the core is safe
          load_done  <= 1'b1;
          core_rst_n <= 1'b1;
          r_state    <= S_DONE;
        end

        S_DONE: begin
          in_ready <= 1'b0;
        end

        S_ERROR: begin
          in_ready   <= 1'b0;
          core_rst_n <= 1'b0;
          load_error <= 1'b1;
        end

        default: begin
          in_ready   <= 1'b0;
          load_error <= 1'b1;
          r_state    <= S_ERROR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed and randomized image loads checked against a byte-stream reference model.
// Latency: checks sample 1 time unit after each rising edge; an imem capture runs on the falling edge.
// Backpressure: the sender only counts a byte as sent when in_valid and in_ready were both high at an edge.
module tb_imem_boot_loader;

  localparam int          DEPTH = 64;
  localparam int          AW    = 6;
  localparam logic [31:0] NOP   = 32'h00000013;
`ifdef CHECKSUM_EN
  localparam int DONE_LAG = 2;
`else
  localparam int DONE_LAG = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst_n;
  logic          load_done;
  logic          load_error;
  logic [AW:0]   words_loaded;

  always #5 clk = ~clk;

  imem_boot_loader dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_rst_n   (core_rst_n),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  int errors = 0;
  int checks = 0;

  // imem image as seen through the write port, plus timing bookkeeping
  logic [31:0] cap_mem [DEPTH];
  int          cyc = 0;
  int          wr_count = 0;
  int          last_we_cyc = -1;
  int          done_cyc = -1;
  bit          overlap = 1'b0;

  // Expected results from the reference model
  logic [7:0]  stream [$];
  logic [31:0] exp_mem [DEPTH];
  bit          exp_done;
  bit          exp_err;
  int          exp_words;
  int          exp_post;

  // Falling-edge monitor: captures imem writes and when load_done first appears
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) cap_mem[i] <= 'x;
      wr_count    <= 0;
      last_we_cyc <= -1;
      done_cyc    <= -1;
      overlap     <= 1'b0;
    end else begin
      if (imem_we) begin
        cap_mem[imem_addr] <= imem_wdata;
        wr_count           <= wr_count + 1;
        last_we_cyc        <= cyc;
      end
      if (load_done && done_cyc < 0) done_cyc <= cyc;
      if (imem_we && (load_done || core_rst_n)) overlap <= 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, ".in_ready"},     64'(in_ready),     64'(0));
    chk({nm, ".imem_we"},      64'(imem_we),      64'(0));
    chk({nm, ".imem_addr"},    64'(imem_addr),    64'(0));
    chk({nm, ".imem_wdata"},   64'(imem_wdata),   64'(0));
    chk({nm, ".core_rst_n"},   64'(core_rst_n),   64'(0));
    chk({nm, ".load_done"},    64'(load_done),    64'(0));
    chk({nm, ".load_error"},   64'(load_error),   64'(0));
    chk({nm, ".words_loaded"}, 64'(words_loaded), 64'(0));
  endtask

  // Called with rst just released: 64 NOP writes at ascending addresses, then in_ready
  task automatic check_fill();
    for (int i = 0; i < DEPTH; i++) begin
      step();
      chk($sformatf("fill[%0d]", i),
          64'({imem_we, in_ready, load_done, core_rst_n, words_loaded, imem_addr, imem_wdata}),
          64'({1'b1, 1'b0, 1'b0, 1'b0, (AW + 1)'(0), AW'(i), NOP}));
    end
    step();
    chk("fill_exit", 64'({in_ready, imem_we}), 64'(2'b10));
  endtask

  task automatic reset_and_fill();
    in_valid = 1'b0;
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    check_fill();
  endtask

  // gap_pct: chance of an idle cycle; toggle: in_valid alternates every cycle instead
  task automatic send_stream(input string nm, input int gap_pct, input bit toggle);
    int idx = 0;
    int budget = 40 * stream.size() + 200;
    bit acc;
    bit phase = 1'b0;
    while (idx < stream.size() && budget > 0) begin
      if (toggle) begin
        in_valid = phase;
        phase = !phase;
      end else begin
        in_valid = (int'($urandom_range(99)) >= gap_pct);
      end
      in_data = in_valid ? stream[idx] : 8'($urandom);
      acc = in_valid && in_ready;
      step();
      if (acc) idx++;
      budget--;
    end
    in_valid = 1'b0;
    chk({nm, ".bytes_sent"}, 64'(idx), 64'(stream.size()));
  endtask

  task automatic build_random(input int n);
    logic [7:0] b;
    stream.delete();
    stream.push_back(8'(n));
    stream.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      stream.push_back(b);
    end
`ifdef CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < 4 * n; i++) x = x ^ stream[2 + i];
      stream.push_back(x);
    end
`endif
  endtask

  task automatic build_spec();
    stream = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h40, 8'h06};
`ifdef CHECKSUM_EN
    stream.push_back(8'h97);
`endif
  endtask

  // Reference model: what imem and the status outputs must hold after the stream is consumed
  task automatic model();
    int n;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = NOP;
    n = int'({stream[1], stream[0]});
    exp_err = 1'b0;
    exp_words = 0;
    exp_post = 0;
    if (n > DEPTH) begin
      exp_err = 1'b1;
    end else begin
      for (int w = 0; w < n; w++)
        exp_mem[w] = {stream[2 + 4 * w + 3], stream[2 + 4 * w + 2], stream[2 + 4 * w + 1], stream[2 + 4 * w]};
      exp_words = n;
      exp_post = n;
`ifdef CHECKSUM_EN
      begin
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 4 * n; i++) x = x ^ stream[2 + i];
        if (stream[2 + 4 * n] !== x) exp_err = 1'b1;
      end
`endif
    end
    exp_done = !exp_err;
  endtask

  task automatic finish_load(input string nm);
    int bad = 0;
    repeat (3) step();
    model();
    chk({nm, ".load_done"},    64'(load_done),    64'(exp_done));
    chk({nm, ".load_error"},   64'(load_error),   64'(exp_err));
    chk({nm, ".core_rst_n"},   64'(core_rst_n),   64'(exp_done));
    chk({nm, ".in_ready"},     64'(in_ready),     64'(0));
    chk({nm, ".words_loaded"}, 64'(words_loaded), 64'(exp_words));
    chk({nm, ".image_writes"}, 64'(wr_count - DEPTH), 64'(exp_post));
    chk({nm, ".done_with_we"}, 64'(overlap),      64'(0));
    for (int i = 0; i < DEPTH; i++) if (cap_mem[i] !== exp_mem[i]) bad++;
    chk({nm, ".mem_bad_words"}, 64'(bad), 64'(0));
  endtask

  task automatic extra_bytes(input string nm);
    int seen = 0;
    int wr0 = wr_count;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data = 8'($urandom);
      if (in_ready) seen++;
      step();
    end
    in_valid = 1'b0;
    step();
    chk({nm, ".extra_accepted"}, 64'(seen), 64'(0));
    chk({nm, ".extra_writes"},   64'(wr_count - wr0), 64'(0));
    chk({nm, ".still_done"},     64'(load_done), 64'(1));
  endtask

  initial begin
    int n;
    int gap;

    // Outputs while reset is held
    repeat (3) step();
    check_zero("reset");

    // Spec image, continuous valid
    reset_and_fill();
    build_spec();
    send_stream("spec", 0, 1'b0);
    finish_load("spec");
    chk("spec.mem0", 64'(cap_mem[0]), 64'(32'h00500093));
    chk("spec.mem1", 64'(cap_mem[1]), 64'(32'h06400113));
    chk("spec.done_lag", 64'(done_cyc - last_we_cyc), 64'(DONE_LAG));
    extra_bytes("spec");

    // Same image with in_valid toggling every cycle, then bytes after DONE
    reset_and_fill();
    build_spec();
    send_stream("toggle", 0, 1'b1);
    finish_load("toggle");
    chk("toggle.mem0", 64'(cap_mem[0]), 64'(32'h00500093));
    chk("toggle.mem1", 64'(cap_mem[1]), 64'(32'h06400113));
    extra_bytes("toggle");

`ifdef CHECKSUM_EN
    // Wrong checksum byte
    reset_and_fill();
    build_spec();
    stream[stream.size() - 1] = 8'h00;
    send_stream("bad_csum", 0, 1'b0);
    finish_load("bad_csum");
`endif

    // Oversized header N=65: error on the next cycle, no data writes
    reset_and_fill();
    stream = '{8'h41, 8'h00};
    send_stream("n65", 0, 1'b0);
    chk("n65.err_next_cycle", 64'(load_error), 64'(1));
    finish_load("n65");

    // Largest legal image
    reset_and_fill();
    build_random(DEPTH);
    send_stream("n64", 10, 1'b0);
    finish_load("n64");

    // Empty image
    reset_and_fill();
    build_random(0);
    send_stream("n0", 0, 1'b0);
    finish_load("n0");

    // Randomized images and pacing
    for (int k = 0; k < 5; k++) begin
      n = int'($urandom_range(1, 20));
      gap = int'($urandom_range(0, 60));
      reset_and_fill();
      build_random(n);
`ifdef CHECKSUM_EN
      if (k == 2) stream[stream.size() - 1] = stream[stream.size() - 1] ^ 8'h5A;
`endif
      send_stream($sformatf("rand%0d", k), gap, 1'b0);
      finish_load($sformatf("rand%0d", k));
    end

    // Reset after five data bytes discards the partial image and restarts the fill
    reset_and_fill();
    build_random(4);
    while (stream.size() > 7) void'(stream.pop_back());
    send_stream("midrst", 0, 1'b0);
    chk("midrst.words_before", 64'(words_loaded), 64'(1));
    rst = 1'b0;
    step();
    check_zero("midrst");
    rst = 1'b1;
    check_fill();
    build_random(3);
    send_stream("after_midrst", 20, 1'b0);
    finish_load("after_midrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
